// File: rtl/pipeline_stage_ctrl_pkg.sv
// Shared types for the pipeline latch controller: latch record, drain FSM states,
// bubble constant and HALT decode helper.
package pipeline_stage_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  valid;
    } pipe_latch_t;

    localparam word_t       NOP_INSTR   = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE = 6'b11_1111;
    localparam pipe_latch_t BUBBLE      = '{instr: NOP_INSTR, npc: 32'h0000_0000, valid: 1'b0};

    function automatic logic is_halt(input word_t instr);
        return (instr[31:26] == HALT_OPCODE);
    endfunction

endpackage

// File: rtl/pipeline_stage_ctrl_stage_reg.sv
// One pipeline latch (instr/npc/valid) with freeze > flush > enable priority.
module pipe_stage_reg
    import pipeline_stage_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        advance,
    input  logic        flush,
    input  logic        enable,
    input  logic [31:0] instr_in,
    input  logic [31:0] npc_in,
    input  logic        valid_in,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        valid_out
);

    pipe_latch_t latch_q;
    pipe_latch_t latch_d;

    // Next latch value: a global freeze overrides any flush or enable request.
    always_comb begin
        latch_d = latch_q;
        if (!advance) begin
            latch_d = latch_q;
        end else if (flush) begin
            latch_d = BUBBLE;
        end else if (enable) begin
            latch_d = '{instr: instr_in, npc: npc_in, valid: valid_in};
        end else begin
            latch_d = latch_q;
        end
    end

    // Latch register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            latch_q <= BUBBLE;
        end else begin
            latch_q <= latch_d;
        end
    end

    assign instr_out = latch_q.instr;
    assign npc_out   = latch_q.npc;
    assign valid_out = latch_q.valid;

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Pipeline latch controller: four stage latches steered by hazard-unit controls and
// cache handshakes, HALT drain FSM and saturating stall/freeze/flush counters.
module pipeline_stage_ctrl
    import pipeline_stage_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic [31:0]      instr_IF,
    input  logic [31:0]      npc_IF,
    input  logic             flush_ID,
    input  logic             flush_EX,
    input  logic             flush_MEM,
    input  logic             enable_ID,
    input  logic             enable_EX,
    input  logic             enable_MEM,
    input  logic             pc_stall,
    output logic [31:0]      instr_ID,
    output logic [31:0]      instr_EX,
    output logic [31:0]      instr_MEM,
    output logic [31:0]      instr_WB,
    output logic [31:0]      npc_ID,
    output logic [31:0]      npc_EX,
    output logic [31:0]      npc_MEM,
    output logic [31:0]      npc_WB,
    output logic             valid_ID,
    output logic             valid_EX,
    output logic             valid_MEM,
    output logic             valid_WB,
    output logic             pc_WEN,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pipe_state_t      state_q, state_d;
    logic [2:0]       drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] freeze_q, freeze_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic        advance_s;
    logic        stage_adv_s;
    logic        run_s;
    logic [31:0] if_instr_s;
    logic [31:0] if_npc_s;
    logic        if_valid_s;

    assign advance_s   = ihit & ~(dmem_req & ~dhit);
    assign run_s       = (state_q == RUN);
    assign stage_adv_s = advance_s & (state_q != HALTED);
    assign pc_WEN      = advance_s & ~pc_stall & run_s;
    assign halt        = (state_q == HALTED);

    // Fetch feeds IF/ID only while running; draining pushes bubbles behind the HALT.
    always_comb begin
        if (run_s) begin
            if_instr_s = instr_IF;
            if_npc_s   = npc_IF;
            if_valid_s = 1'b1;
        end else begin
            if_instr_s = NOP_INSTR;
            if_npc_s   = 32'h0000_0000;
            if_valid_s = 1'b0;
        end
    end

    pipe_stage_reg u_if_id (
        .CLK(CLK), .nRST(nRST), .advance(stage_adv_s), .flush(flush_ID), .enable(enable_ID),
        .instr_in(if_instr_s), .npc_in(if_npc_s), .valid_in(if_valid_s),
        .instr_out(instr_ID), .npc_out(npc_ID), .valid_out(valid_ID)
    );

    pipe_stage_reg u_id_ex (
        .CLK(CLK), .nRST(nRST), .advance(stage_adv_s), .flush(flush_EX), .enable(enable_EX),
        .instr_in(instr_ID), .npc_in(npc_ID), .valid_in(valid_ID),
        .instr_out(instr_EX), .npc_out(npc_EX), .valid_out(valid_EX)
    );

    pipe_stage_reg u_ex_mem (
        .CLK(CLK), .nRST(nRST), .advance(stage_adv_s), .flush(flush_MEM), .enable(enable_MEM),
        .instr_in(instr_EX), .npc_in(npc_EX), .valid_in(valid_EX),
        .instr_out(instr_MEM), .npc_out(npc_MEM), .valid_out(valid_MEM)
    );

    pipe_stage_reg u_mem_wb (
        .CLK(CLK), .nRST(nRST), .advance(stage_adv_s), .flush(1'b0), .enable(1'b1),
        .instr_in(instr_MEM), .npc_in(npc_MEM), .valid_in(valid_MEM),
        .instr_out(instr_WB), .npc_out(npc_WB), .valid_out(valid_WB)
    );

    // Drain FSM: the HALT in MEM triggers regardless of a same-cycle flush_MEM,
    // which only affects what loads into EX/MEM.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (advance_s && valid_MEM && is_halt(instr_MEM)) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (drain_q <= 3'd1) begin
                    state_d = HALTED;
                    drain_d = 3'd0;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                drain_d = 3'd0;
            end
        endcase
    end

    // Performance counters, active only in RUN.
    always_comb begin
        stall_d  = stall_q;
        freeze_d = freeze_q;
        flush_d  = flush_q;
        if (run_s) begin
            if (advance_s) begin
                stall_d = pc_stall ? sat_inc(stall_q) : stall_q;
                flush_d = (flush_ID | flush_EX | flush_MEM) ? sat_inc(flush_q) : flush_q;
            end else begin
                freeze_d = sat_inc(freeze_q);
            end
        end else begin
            stall_d = stall_q;
        end
    end

    // State, drain counter and performance counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            drain_q  <= 3'd0;
            stall_q  <= '0;
            freeze_q <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            stall_q  <= stall_d;
            freeze_q <= freeze_d;
            flush_q  <= flush_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign freeze_cnt = freeze_q;
    assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Directed vector table plus hand-written HALT/drain and mid-drain reset sequences.
module tb_pipeline_stage_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dmem_req, pc_stall;
    logic [31:0] instr_IF, npc_IF;
    logic        flush_ID, flush_EX, flush_MEM;
    logic        enable_ID, enable_EX, enable_MEM;
    logic [31:0] instr_ID, instr_EX, instr_MEM, instr_WB;
    logic [31:0] npc_ID, npc_EX, npc_MEM, npc_WB;
    logic        valid_ID, valid_EX, valid_MEM, valid_WB;
    logic        pc_WEN, halt;
    logic [31:0] stall_cnt, freeze_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pipeline_stage_ctrl #(.CNT_W(32), .DRAIN_CYCLES(1)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .instr_IF(instr_IF), .npc_IF(npc_IF),
        .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_MEM(flush_MEM),
        .enable_ID(enable_ID), .enable_EX(enable_EX), .enable_MEM(enable_MEM),
        .pc_stall(pc_stall),
        .instr_ID(instr_ID), .instr_EX(instr_EX), .instr_MEM(instr_MEM), .instr_WB(instr_WB),
        .npc_ID(npc_ID), .npc_EX(npc_EX), .npc_MEM(npc_MEM), .npc_WB(npc_WB),
        .valid_ID(valid_ID), .valid_EX(valid_EX), .valid_MEM(valid_MEM), .valid_WB(valid_WB),
        .pc_WEN(pc_WEN), .halt(halt),
        .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic        ihit, dhit, dreq, stall;
        logic [2:0]  fl, en;        // {ID, EX, MEM}
        logic [31:0] instr, npc;
        logic        wen;           // pc_WEN before the edge
        logic [31:0] e_id, e_ex, e_mem, e_wb, e_npc_id;
        logic [3:0]  e_val;         // {ID, EX, MEM, WB} after the edge
        int          e_stall, e_freeze, e_flush;
    } vec_t;

    vec_t vecs[14];

    localparam logic [31:0] HALT_I = 32'hFFFF_FFFF;

    function automatic logic [31:0] ins(input int k);
        return 32'h0022_1800 | 32'(k);
    endfunction

    function automatic vec_t mk(input logic ih, input logic dh, input logic dr, input logic st,
                                input logic [2:0] fl, input logic [2:0] en,
                                input logic [31:0] instr, input logic [31:0] npc, input logic wen,
                                input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                                input logic [31:0] wb, input logic [31:0] npcid, input logic [3:0] val,
                                input int s, input int f, input int fc);
        vec_t v;
        v.ihit = ih; v.dhit = dh; v.dreq = dr; v.stall = st; v.fl = fl; v.en = en;
        v.instr = instr; v.npc = npc; v.wen = wen;
        v.e_id = id; v.e_ex = ex; v.e_mem = mem; v.e_wb = wb; v.e_npc_id = npcid; v.e_val = val;
        v.e_stall = s; v.e_freeze = f; v.e_flush = fc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ih, input logic dh, input logic dr, input logic st,
                         input logic [2:0] fl, input logic [2:0] en,
                         input logic [31:0] instr, input logic [31:0] npc);
        ihit = ih; dhit = dh; dmem_req = dr; pc_stall = st;
        {flush_ID, flush_EX, flush_MEM} = fl;
        {enable_ID, enable_EX, enable_MEM} = en;
        instr_IF = instr; npc_IF = npc;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 32'h0, 32'h0);
        #1;
        chk("reset instr_WB", 64'(instr_WB), 64'h0);
        chk("reset valid", 64'({valid_ID, valid_EX, valid_MEM, valid_WB}), 64'h0);
        chk("reset pc_WEN", 64'(pc_WEN), 64'h0);
        chk("reset halt", 64'(halt), 64'h0);
        chk("reset counters", 64'(stall_cnt | freeze_cnt | flush_cnt), 64'h0);
        tick();
        tick();
        nRST = 1'b1;

        vecs[0]  = mk(1,1,0,0, 3'b000,3'b111, ins(1),32'd4,  1, ins(1),0,0,0,            32'd4,  4'b1000, 0,0,0);
        vecs[1]  = mk(1,1,0,0, 3'b000,3'b111, ins(2),32'd8,  1, ins(2),ins(1),0,0,       32'd8,  4'b1100, 0,0,0);
        vecs[2]  = mk(1,1,0,0, 3'b000,3'b111, ins(3),32'd12, 1, ins(3),ins(2),ins(1),0,  32'd12, 4'b1110, 0,0,0);
        vecs[3]  = mk(1,1,0,0, 3'b000,3'b111, ins(4),32'd16, 1, ins(4),ins(3),ins(2),ins(1), 32'd16, 4'b1111, 0,0,0);
        vecs[4]  = mk(1,1,0,0, 3'b000,3'b111, ins(5),32'd20, 1, ins(5),ins(4),ins(3),ins(2), 32'd20, 4'b1111, 0,0,0);
        vecs[5]  = mk(1,1,0,1, 3'b010,3'b011, ins(6),32'd24, 0, ins(5),0,ins(4),ins(3),  32'd20, 4'b1011, 1,0,1);
        vecs[6]  = mk(1,1,0,0, 3'b000,3'b111, ins(6),32'd24, 1, ins(6),ins(5),0,ins(4),  32'd24, 4'b1101, 1,0,1);
        vecs[7]  = mk(1,0,1,0, 3'b111,3'b111, ins(7),32'd28, 0, ins(6),ins(5),0,ins(4),  32'd24, 4'b1101, 1,1,1);
        vecs[8]  = mk(1,0,1,0, 3'b111,3'b111, ins(7),32'd28, 0, ins(6),ins(5),0,ins(4),  32'd24, 4'b1101, 1,2,1);
        vecs[9]  = mk(1,0,1,0, 3'b111,3'b111, ins(7),32'd28, 0, ins(6),ins(5),0,ins(4),  32'd24, 4'b1101, 1,3,1);
        vecs[10] = mk(1,1,0,0, 3'b000,3'b111, ins(7),32'd28, 1, ins(7),ins(6),ins(5),0,  32'd28, 4'b1110, 1,3,1);
        vecs[11] = mk(1,1,0,0, 3'b111,3'b111, ins(8),32'd32, 1, 0,0,0,ins(5),            32'd0,  4'b0001, 1,3,2);
        vecs[12] = mk(1,1,0,0, 3'b000,3'b111, ins(9),32'd36, 1, ins(9),0,0,0,            32'd36, 4'b1000, 1,3,2);
        vecs[13] = mk(0,1,0,0, 3'b000,3'b111, ins(10),32'd40,0, ins(9),0,0,0,            32'd36, 4'b1000, 1,4,2);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ihit, vecs[i].dhit, vecs[i].dreq, vecs[i].stall,
                  vecs[i].fl, vecs[i].en, vecs[i].instr, vecs[i].npc);
            #1;
            chk($sformatf("v%0d pc_WEN", i), 64'(pc_WEN), 64'(vecs[i].wen));
            tick();
            chk($sformatf("v%0d instr_ID", i), 64'(instr_ID), 64'(vecs[i].e_id));
            chk($sformatf("v%0d instr_EX", i), 64'(instr_EX), 64'(vecs[i].e_ex));
            chk($sformatf("v%0d instr_MEM", i), 64'(instr_MEM), 64'(vecs[i].e_mem));
            chk($sformatf("v%0d instr_WB", i), 64'(instr_WB), 64'(vecs[i].e_wb));
            chk($sformatf("v%0d npc_ID", i), 64'(npc_ID), 64'(vecs[i].e_npc_id));
            chk($sformatf("v%0d valid", i), 64'({valid_ID, valid_EX, valid_MEM, valid_WB}), 64'(vecs[i].e_val));
            chk($sformatf("v%0d stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].e_stall));
            chk($sformatf("v%0d freeze_cnt", i), 64'(freeze_cnt), 64'(vecs[i].e_freeze));
            chk($sformatf("v%0d flush_cnt", i), 64'(flush_cnt), 64'(vecs[i].e_flush));
        end

        // HALT travels IF -> MEM, then drains one cycle before halting.
        drive(1,1,0,0, 3'b000,3'b111, HALT_I, 32'd40); tick();
        drive(1,1,0,0, 3'b000,3'b111, ins(11), 32'd44); tick();
        drive(1,1,0,0, 3'b000,3'b111, ins(12), 32'd48); tick();
        chk("halt in MEM", 64'(instr_MEM), 64'(HALT_I));
        drive(1,1,0,0, 3'b000,3'b111, ins(13), 32'd52);
        #1;
        chk("halt cycle pc_WEN", 64'(pc_WEN), 64'h1);
        tick();
        chk("drain halt", 64'(halt), 64'h0);
        chk("drain pc_WEN", 64'(pc_WEN), 64'h0);
        chk("drain WB", 64'(instr_WB), 64'(HALT_I));
        drive(1,1,0,0, 3'b000,3'b111, ins(14), 32'd56); tick();
        chk("halted halt", 64'(halt), 64'h1);
        chk("halted ID bubble", 64'({instr_ID, 31'h0, valid_ID}), 64'h0);
        chk("halted WB", 64'(instr_WB), 64'(ins(11)));
        for (int k = 0; k < 3; k++) begin
            drive(1,1,0,k[0], 3'b100,3'b111, ins(20+k), 32'd60);
            tick();
            chk($sformatf("sticky%0d halt", k), 64'(halt), 64'h1);
            chk($sformatf("sticky%0d pc_WEN", k), 64'(pc_WEN), 64'h0);
            chk($sformatf("sticky%0d EX", k), 64'(instr_EX), 64'(ins(13)));
            chk($sformatf("sticky%0d WB", k), 64'(instr_WB), 64'(ins(11)));
            chk($sformatf("sticky%0d flush_cnt", k), 64'(flush_cnt), 64'd2);
            chk($sformatf("sticky%0d stall_cnt", k), 64'(stall_cnt), 64'd1);
        end

        // Reset out of HALTED, trigger a drain with HALT flushed in MEM, then reset mid-drain.
        nRST = 1'b0;
        #1;
        chk("rst2 halt", 64'(halt), 64'h0);
        tick();
        nRST = 1'b1;
        drive(1,1,0,0, 3'b000,3'b111, HALT_I, 32'd4); tick();
        drive(1,1,0,0, 3'b000,3'b111, ins(15), 32'd8); tick();
        drive(1,1,0,0, 3'b000,3'b111, ins(16), 32'd12); tick();
        drive(1,1,0,0, 3'b001,3'b111, ins(17), 32'd16); tick();
        chk("flushed halt drain pc_WEN", 64'(pc_WEN), 64'h0);
        chk("flushed halt MEM valid", 64'(valid_MEM), 64'h0);
        chk("flushed halt WB", 64'(instr_WB), 64'(HALT_I));
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst instr_WB", 64'(instr_WB), 64'h0);
        chk("midrst instr_ID", 64'(instr_ID), 64'h0);
        chk("midrst valid", 64'({valid_ID, valid_EX, valid_MEM, valid_WB}), 64'h0);
        chk("midrst counters", 64'(stall_cnt | freeze_cnt | flush_cnt), 64'h0);
        #1;
        nRST = 1'b1;
        drive(1,1,0,0, 3'b000,3'b111, ins(30), 32'd4);
        #1;
        chk("resume pc_WEN", 64'(pc_WEN), 64'h1);
        tick();
        chk("resume instr_ID", 64'(instr_ID), 64'(ins(30)));
        chk("resume valid_ID", 64'(valid_ID), 64'h1);
        tick();
        tick();
        chk("resume halt", 64'(halt), 64'h0);
        chk("resume pc_WEN2", 64'(pc_WEN), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
